alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execution-side consumer of the reservation station's issue interface (exe_* bundle). Evaluates RV32I integer, branch and jump operations.
- Produces the ALU result broadcast (alu_valid / alu_rob_id / alu_data) that the RS, LSB and ROB snoop.
- Also produces branch/jump resolution for the ROB.
- Fixed-latency pipeline, one issue accepted per cycle, no backpressure. The RS never stalls its issue.

Parameters:
- LATENCY, 1, cycles from exe_valid sampled to alu_valid asserted. Legal values are 1 and 2.
- ROB_ID_W, 4, ROB tag width. Must equal the codebase ROB_ID_WID.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global clock enable; when low, all state holds
- rollback  in  1  flush in-flight ops, synchronous to clk
- exe_valid  in  1  issue strobe from RS
- exe_opcode  in  7  RV32I major opcode
- exe_func3  in  3  funct3
- exe_func1  in  1  instr[30] (SUB/SRA select)
- exe_data1  in  32  rs1 value
- exe_data2  in  32  rs2 value
- exe_imm  in  32  sign-extended I/U immediate
- exe_off  in  32  sign-extended B/J offset
- exe_pc  in  32  instruction PC
- exe_rob_target  in  ROB_ID_W  destination ROB tag
- exe_is_c_extend  in  1  compressed instruction; link/fallthrough is +2, not +4
- alu_valid  out  1  result broadcast strobe
- alu_rob_id  out  ROB_ID_W  tag of the result
- alu_data  out  32  rd writeback value
- alu_is_ctrl  out  1  result belongs to a branch, JAL or JALR
- alu_taken  out  1  control transfer taken
- alu_target  out  32  resolved next PC for control ops

Behaviour:
- Reset, asynchronous with rst low: all outputs 0, pipeline valid bits 0.
- rdy low: no register changes. Outputs hold. An exe_valid presented that cycle is lost; the RS holds its output under rdy, so this is consistent.
- Stage structure:
  - LATENCY=1: combinational compute from exe_*, registered into the output bundle at posedge.
  - LATENCY=2: exe_* is first captured into an input register (s1_valid + fields), then computed and registered.
  - Throughput is 1 op/cycle in both cases.
- alu_valid is a single-cycle pulse per accepted op. It deasserts the cycle after unless a new op follows back-to-back.
- Rollback, sampled at posedge with rdy high:
  - Clears alu_valid and s1_valid.
  - A concurrent exe_valid is dropped.
  - Rollback has priority over everything except reset.
- Operations (all arithmetic mod 2^32):
  - LUI: data = imm.
  - AUIPC: data = pc + imm.
  - OP-IMM / OP: second operand is imm / data2.
    - func3 000: ADD, or SUB if OP and func1=1 (ADDI ignores func1).
    - func3 001: SLL.
    - func3 010: SLT (signed).
    - func3 011: SLTU.
    - func3 100: XOR.
    - func3 101: SRL, or SRA if func1=1.
    - func3 110: OR.
    - func3 111: AND.
    - Shift amount is operand[4:0].
  - BRANCH, func3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU:
    - alu_is_ctrl=1.
    - alu_taken = condition.
    - alu_target = taken ? pc+off : pc+step.
    - alu_data = 0.
  - JAL: data = pc+step, is_ctrl=1, taken=1, target = pc+off.
  - JALR: data = pc+step, is_ctrl=1, taken=1, target = (data1+imm) & ~1.
  - step = exe_is_c_extend ? 2 : 4.
  - Non-control ops: alu_is_ctrl=0, alu_taken=0, alu_target=0.
  - Unknown opcode or unused branch func3: still broadcast, with data=0 and is_ctrl=0, so the ROB entry completes and never deadlocks.
- alu_rob_id always equals the exe_rob_target of the op producing that alu_valid pulse. No reordering.

Decomposition:
- Shared package/`const.v`:
  - opcode constants OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_OPIMM, OPC_OP
  - funct3 constants
  - DATA_WID, ROB_ID_WID macros
- One natural sub-module: alu_core. Purely combinational; maps (opcode, func3, func1, op1, op2, imm, off, pc, c_ext) to (data, is_ctrl, taken, target).
- alu_exec owns only the pipeline registers, rdy/rollback/reset control and LATENCY generate.

Test Plan:
- ADD/SUB: OP, func3=000, data1=5, data2=7, func1=0 -> alu_valid one cycle later with data=12 and the issued tag; same with func1=1 -> data=0xFFFFFFFE.
- SRA vs SRL: data1=0x80000000, imm shamt=4 on OP-IMM func3=101 -> func1=1 gives 0xF8000000; func1=0 gives 0x08000000.
- BLT compressed: pc=0x100, off=0x20, data1=-1, data2=1, c_ext=1 -> is_ctrl=1, taken=1, target=0x120. Swap operands -> taken=0, target=0x102.
- JALR: pc=0x200, data1=0x1001, imm=2 -> data=0x204, target=0x1002.
- Rollback kill: issue op, then assert rollback in the same cycle (LATENCY=1), or one cycle later (LATENCY=2) -> no alu_valid pulse. Next op after rollback broadcasts normally.
- Back-to-back, rdy stall, reset: 4 consecutive issues with tags 1..4, rdy low mid-stream for 2 cycles -> outputs frozen, then tags 1..4 broadcast in order. Reset asserted asynchronously mid-stream -> alu_valid drops immediately with no clock.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared constants and types for the integer execution unit: RV32I opcode
// and funct3 encodings plus the datapath and ROB tag widths.
package alu_exec_pkg;

  localparam int DATA_WID   = 32;
  localparam int ROB_ID_WID = 4;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_exec_core.sv
// Purely combinational RV32I integer/branch/jump evaluator. Unknown opcodes
// and unused branch encodings produce an all-zero, non-control result.
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic                func1,
  input  logic [DATA_WID-1:0] op1,
  input  logic [DATA_WID-1:0] op2,
  input  logic [DATA_WID-1:0] imm,
  input  logic [DATA_WID-1:0] off,
  input  logic [DATA_WID-1:0] pc,
  input  logic                c_ext,
  output logic [DATA_WID-1:0] data,
  output logic                is_ctrl,
  output logic                taken,
  output logic [DATA_WID-1:0] target
);

  logic [DATA_WID-1:0]        step;
  logic [DATA_WID-1:0]        link;
  logic [DATA_WID-1:0]        br_target;
  logic [DATA_WID-1:0]        opb;
  logic [4:0]                 shamt;
  logic signed [DATA_WID-1:0] sra_res;
  logic                       is_sub;
  logic                       br_cond;
  logic                       br_known;

  assign step      = c_ext ? 32'd2 : 32'd4;
  assign link      = pc + step;
  assign br_target = pc + off;
  assign opb       = (opcode == OPC_OP) ? op2 : imm;
  assign shamt     = opb[4:0];
  assign sra_res   = $signed(op1) >>> shamt;
  assign is_sub    = (opcode == OPC_OP) && func1;

  // Branch condition decode; unused funct3 values are flagged as unknown
  always_comb begin
    br_cond  = 1'b0;
    br_known = 1'b1;
    case (func3)
      F3_BEQ:  br_cond = (op1 == op2);
      F3_BNE:  br_cond = (op1 != op2);
      F3_BLT:  br_cond = ($signed(op1) < $signed(op2));
      F3_BGE:  br_cond = ($signed(op1) >= $signed(op2));
      F3_BLTU: br_cond = (op1 < op2);
      F3_BGEU: br_cond = (op1 >= op2);
      default: br_known = 1'b0;
    endcase
  end

  // Result and control-transfer selection by opcode
  always_comb begin
    data    = '0;
    is_ctrl = 1'b0;
    taken   = 1'b0;
    target  = '0;
    case (opcode)
      OPC_LUI:   data = imm;
      OPC_AUIPC: data = pc + imm;
      OPC_OP, OPC_OPIMM: begin
        case (func3)
          F3_ADD:  data = is_sub ? (op1 - opb) : (op1 + opb);
          F3_SLL:  data = op1 << shamt;
          F3_SLT:  data = {31'b0, $signed(op1) < $signed(opb)};
          F3_SLTU: data = {31'b0, op1 < opb};
          F3_XOR:  data = op1 ^ opb;
          F3_SR:   data = func1 ? $unsigned(sra_res) : (op1 >> shamt);
          F3_OR:   data = op1 | opb;
          default: data = op1 & opb;
        endcase
      end
      OPC_BR: begin
        if (br_known) begin
          is_ctrl = 1'b1;
          taken   = br_cond;
          target  = br_cond ? br_target : link;
        end
      end
      OPC_JAL: begin
        data    = link;
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = br_target;
      end
      OPC_JALR: begin
        data    = link;
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = (op1 + imm) & ~32'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Fixed-latency ALU pipeline: optional input register (LATENCY=2), the
// combinational core, and the registered result broadcast. Handles the global
// clock enable, rollback flush and asynchronous reset.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int LATENCY  = 1,
  parameter int ROB_ID_W = ROB_ID_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                exe_valid,
  input  logic [6:0]          exe_opcode,
  input  logic [2:0]          exe_func3,
  input  logic                exe_func1,
  input  logic [DATA_WID-1:0] exe_data1,
  input  logic [DATA_WID-1:0] exe_data2,
  input  logic [DATA_WID-1:0] exe_imm,
  input  logic [DATA_WID-1:0] exe_off,
  input  logic [DATA_WID-1:0] exe_pc,
  input  logic [ROB_ID_W-1:0] exe_rob_target,
  input  logic                exe_is_c_extend,
  output logic                alu_valid,
  output logic [ROB_ID_W-1:0] alu_rob_id,
  output logic [DATA_WID-1:0] alu_data,
  output logic                alu_is_ctrl,
  output logic                alu_taken,
  output logic [DATA_WID-1:0] alu_target
);

  logic                c_valid;
  logic [6:0]          c_opcode;
  logic [2:0]          c_func3;
  logic                c_func1;
  logic [DATA_WID-1:0] c_data1, c_data2, c_imm, c_off, c_pc;
  logic [ROB_ID_W-1:0] c_rob;
  logic                c_ext;

  logic [DATA_WID-1:0] core_data, core_target;
  logic                core_ctrl, core_taken;

  generate
    if (LATENCY == 2) begin : g_s1
      logic                s1_valid;
      logic [6:0]          s1_opcode;
      logic [2:0]          s1_func3;
      logic                s1_func1;
      logic [DATA_WID-1:0] s1_data1, s1_data2, s1_imm, s1_off, s1_pc;
      logic [ROB_ID_W-1:0] s1_rob;
      logic                s1_ext;

      // Input capture stage; rollback kills whatever would enter or sits here
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_valid  <= 1'b0;
          s1_opcode <= '0;
          s1_func3  <= '0;
          s1_func1  <= 1'b0;
          s1_data1  <= '0;
          s1_data2  <= '0;
          s1_imm    <= '0;
          s1_off    <= '0;
          s1_pc     <= '0;
          s1_rob    <= '0;
          s1_ext    <= 1'b0;
        end else if (rdy) begin
          s1_valid <= exe_valid && !rollback;
          if (exe_valid) begin
            s1_opcode <= exe_opcode;
            s1_func3  <= exe_func3;
            s1_func1  <= exe_func1;
            s1_data1  <= exe_data1;
            s1_data2  <= exe_data2;
            s1_imm    <= exe_imm;
            s1_off    <= exe_off;
            s1_pc     <= exe_pc;
            s1_rob    <= exe_rob_target;
            s1_ext    <= exe_is_c_extend;
          end
        end
      end

      assign c_valid  = s1_valid;
      assign c_opcode = s1_opcode;
      assign c_func3  = s1_func3;
      assign c_func1  = s1_func1;
      assign c_data1  = s1_data1;
      assign c_data2  = s1_data2;
      assign c_imm    = s1_imm;
      assign c_off    = s1_off;
      assign c_pc     = s1_pc;
      assign c_rob    = s1_rob;
      assign c_ext    = s1_ext;
    end else begin : g_direct
      assign c_valid  = exe_valid;
      assign c_opcode = exe_opcode;
      assign c_func3  = exe_func3;
      assign c_func1  = exe_func1;
      assign c_data1  = exe_data1;
      assign c_data2  = exe_data2;
      assign c_imm    = exe_imm;
      assign c_off    = exe_off;
      assign c_pc     = exe_pc;
      assign c_rob    = exe_rob_target;
      assign c_ext    = exe_is_c_extend;
    end
  endgenerate

  alu_core u_core (
    .opcode  (c_opcode),
    .func3   (c_func3),
    .func1   (c_func1),
    .op1     (c_data1),
    .op2     (c_data2),
    .imm     (c_imm),
    .off     (c_off),
    .pc      (c_pc),
    .c_ext   (c_ext),
    .data    (core_data),
    .is_ctrl (core_ctrl),
    .taken   (core_taken),
    .target  (core_target)
  );

  // Result broadcast register: one-cycle pulse per op, bus zeroed when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_valid   <= 1'b0;
      alu_rob_id  <= '0;
      alu_data    <= '0;
      alu_is_ctrl <= 1'b0;
      alu_taken   <= 1'b0;
      alu_target  <= '0;
    end else if (rdy) begin
      if (c_valid && !rollback) begin
        alu_valid   <= 1'b1;
        alu_rob_id  <= c_rob;
        alu_data    <= core_data;
        alu_is_ctrl <= core_ctrl;
        alu_taken   <= core_taken;
        alu_target  <= core_target;
      end else begin
        alu_valid   <= 1'b0;
        alu_rob_id  <= '0;
        alu_data    <= '0;
        alu_is_ctrl <= 1'b0;
        alu_taken   <= 1'b0;
        alu_target  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, randomized ops
// against a behavioural model, and hand-written rollback/stall/reset sequences.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int LAT = 1;
  localparam int RW  = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, rollback, exe_valid;
  logic [6:0]    exe_opcode;
  logic [2:0]    exe_func3;
  logic          exe_func1;
  logic [31:0]   exe_data1, exe_data2, exe_imm, exe_off, exe_pc;
  logic [RW-1:0] exe_rob_target;
  logic          exe_is_c_extend;
  logic          alu_valid, alu_is_ctrl, alu_taken;
  logic [RW-1:0] alu_rob_id;
  logic [31:0]   alu_data, alu_target;

  always #5 clk = ~clk;

  alu_exec #(.LATENCY(LAT), .ROB_ID_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_func3(exe_func3),
    .exe_func1(exe_func1), .exe_data1(exe_data1), .exe_data2(exe_data2),
    .exe_imm(exe_imm), .exe_off(exe_off), .exe_pc(exe_pc),
    .exe_rob_target(exe_rob_target), .exe_is_c_extend(exe_is_c_extend),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
    .alu_is_ctrl(alu_is_ctrl), .alu_taken(alu_taken), .alu_target(alu_target)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f1;
    logic [31:0] d1, d2, imm, off, pc;
    logic        c;
    logic [3:0]  tag;
  } op_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ctrl;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic op_t mk(logic [6:0] opc, logic [2:0] f3, logic f1,
                             logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                             logic [31:0] off, logic [31:0] pc, logic c, logic [3:0] tag);
    op_t o;
    o.opcode = opc; o.f3 = f3; o.f1 = f1; o.d1 = d1; o.d2 = d2;
    o.imm = imm; o.off = off; o.pc = pc; o.c = c; o.tag = tag;
    return o;
  endfunction

  function automatic exp_t ex(logic [31:0] data, logic ctrl, logic taken, logic [31:0] target);
    exp_t e;
    e.data = data; e.ctrl = ctrl; e.taken = taken; e.target = target;
    return e;
  endfunction

  // Behavioural reference: RV32I semantics expressed with plain arithmetic
  function automatic exp_t model(op_t o);
    exp_t        e;
    logic [31:0] b, step;
    int          sh;
    logic        cond;
    bit          known;
    e = '0;
    step = o.c ? 32'd2 : 32'd4;
    case (o.opcode)
      OPC_LUI:   e.data = o.imm;
      OPC_AUIPC: e.data = o.pc + o.imm;
      OPC_OP, OPC_OPIMM: begin
        b = (o.opcode == OPC_OP) ? o.d2 : o.imm;
        sh = int'(b % 32);
        case (o.f3)
          3'd0: begin
            if (o.opcode == OPC_OP && o.f1) e.data = o.d1 - b;
            else e.data = o.d1 + b;
          end
          3'd1: e.data = o.d1 << sh;
          3'd2: e.data = ($signed(o.d1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: e.data = (o.d1 < b) ? 32'd1 : 32'd0;
          3'd4: e.data = o.d1 ^ b;
          3'd5: begin
            if (o.f1) e.data = $signed(o.d1) >>> sh;
            else e.data = o.d1 >> sh;
          end
          3'd6: e.data = o.d1 | b;
          default: e.data = o.d1 & b;
        endcase
      end
      OPC_BR: begin
        known = 1;
        cond = 0;
        case (o.f3)
          3'd0: cond = (o.d1 == o.d2);
          3'd1: cond = (o.d1 != o.d2);
          3'd4: cond = ($signed(o.d1) < $signed(o.d2));
          3'd5: cond = ($signed(o.d1) >= $signed(o.d2));
          3'd6: cond = (o.d1 < o.d2);
          3'd7: cond = (o.d1 >= o.d2);
          default: known = 0;
        endcase
        if (known) begin
          e.ctrl = 1;
          e.taken = cond;
          e.target = cond ? o.pc + o.off : o.pc + step;
        end
      end
      OPC_JAL: begin
        e.data = o.pc + step; e.ctrl = 1; e.taken = 1; e.target = o.pc + o.off;
      end
      OPC_JALR: begin
        e.data = o.pc + step; e.ctrl = 1; e.taken = 1;
        e.target = (o.d1 + o.imm) & ~32'd1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic checkOutput(string name, exp_t e, logic [3:0] tag);
    checkValue({name, "_valid"}, {31'b0, alu_valid}, 32'd1);
    checkValue({name, "_rob"}, {28'b0, alu_rob_id}, {28'b0, tag});
    checkValue({name, "_data"}, alu_data, e.data);
    checkValue({name, "_ctrl"}, {31'b0, alu_is_ctrl}, {31'b0, e.ctrl});
    checkValue({name, "_taken"}, {31'b0, alu_taken}, {31'b0, e.taken});
    checkValue({name, "_target"}, alu_target, e.target);
  endtask

  task automatic driveOp(op_t o);
    exe_opcode = o.opcode; exe_func3 = o.f3; exe_func1 = o.f1;
    exe_data1 = o.d1; exe_data2 = o.d2; exe_imm = o.imm; exe_off = o.off;
    exe_pc = o.pc; exe_is_c_extend = o.c; exe_rob_target = o.tag;
  endtask

  // Issue one op for a single cycle and return at the negedge where it is broadcast
  task automatic applyStimulus(op_t o);
    @(negedge clk);
    driveOp(o);
    exe_valid = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask

  vec_t          vecs[$];
  vec_t          v;
  op_t           o;
  exp_t          e;
  logic [3:0]    seen_tag[$];
  logic [31:0]   seen_data[$];
  logic          snap_valid;
  logic [3:0]    snap_rob;
  logic [31:0]   snap_data;
  logic          prev_rdy;
  int            sched_tag[8] = '{1, 2, 3, 3, 3, 4, 0, 0};
  bit            sched_rdy[8] = '{1, 1, 0, 0, 1, 1, 1, 1};

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; exe_valid = 1'b0;
    driveOp(mk(7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 4'd0));

    // Reset state
    repeat (2) @(negedge clk);
    checkValue("rst_valid", {31'b0, alu_valid}, 32'd0);
    checkValue("rst_rob", {28'b0, alu_rob_id}, 32'd0);
    checkValue("rst_data", alu_data, 32'd0);
    checkValue("rst_ctrl", {31'b0, alu_is_ctrl}, 32'd0);
    checkValue("rst_taken", {31'b0, alu_taken}, 32'd0);
    checkValue("rst_target", alu_target, 32'd0);
    rst = 1'b1;

    // Directed vector table with hand-computed expectations
    v.op = mk(OPC_OP, 3'd0, 1'b0, 5, 7, 0, 0, 0, 1'b0, 4'd1);
    v.exp = ex(32'd12, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OP, 3'd0, 1'b1, 5, 7, 0, 0, 0, 1'b0, 4'd2);
    v.exp = ex(32'hFFFFFFFE, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OPIMM, 3'd5, 1'b1, 32'h80000000, 0, 4, 0, 0, 1'b0, 4'd3);
    v.exp = ex(32'hF8000000, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OPIMM, 3'd5, 1'b0, 32'h80000000, 0, 4, 0, 0, 1'b0, 4'd4);
    v.exp = ex(32'h08000000, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_BR, 3'd4, 1'b0, 32'hFFFFFFFF, 1, 0, 32'h20, 32'h100, 1'b1, 4'd5);
    v.exp = ex(0, 1, 1, 32'h120); vecs.push_back(v);
    v.op = mk(OPC_BR, 3'd4, 1'b0, 1, 32'hFFFFFFFF, 0, 32'h20, 32'h100, 1'b1, 4'd6);
    v.exp = ex(0, 1, 0, 32'h102); vecs.push_back(v);
    v.op = mk(OPC_JALR, 3'd0, 1'b0, 32'h1001, 0, 2, 0, 32'h200, 1'b0, 4'd7);
    v.exp = ex(32'h204, 1, 1, 32'h1002); vecs.push_back(v);
    v.op = mk(OPC_JAL, 3'd0, 1'b0, 0, 0, 0, 32'hFFFFFFF0, 32'h300, 1'b1, 4'd8);
    v.exp = ex(32'h302, 1, 1, 32'h2F0); vecs.push_back(v);
    v.op = mk(OPC_LUI, 3'd0, 1'b0, 0, 0, 32'h12345000, 0, 0, 1'b0, 4'd9);
    v.exp = ex(32'h12345000, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_AUIPC, 3'd0, 1'b0, 0, 0, 32'h2000, 0, 32'h1000, 1'b0, 4'd10);
    v.exp = ex(32'h3000, 0, 0, 0); vecs.push_back(v);
    v.op = mk(7'h7F, 3'd0, 1'b0, 9, 9, 9, 9, 9, 1'b0, 4'd11);
    v.exp = ex(0, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_BR, 3'd2, 1'b0, 3, 3, 0, 8, 32'h40, 1'b0, 4'd12);
    v.exp = ex(0, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OPIMM, 3'd0, 1'b1, 10, 99, 3, 0, 0, 1'b0, 4'd13);
    v.exp = ex(32'd13, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OP, 3'd3, 1'b0, 1, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 4'd14);
    v.exp = ex(32'd1, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_OP, 3'd2, 1'b0, 1, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 4'd15);
    v.exp = ex(32'd0, 0, 0, 0); vecs.push_back(v);
    v.op = mk(OPC_BR, 3'd7, 1'b0, 5, 5, 0, 8, 32'h40, 1'b0, 4'd0);
    v.exp = ex(0, 1, 1, 32'h48); vecs.push_back(v);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].op.tag);
      @(negedge clk);
      checkValue($sformatf("vec%0d_pulse", i), {31'b0, alu_valid}, 32'd0);
    end

    // Randomized ops against the behavioural model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 8))
        0: o.opcode = OPC_LUI;
        1: o.opcode = OPC_AUIPC;
        2: o.opcode = OPC_JAL;
        3: o.opcode = OPC_JALR;
        4: o.opcode = OPC_BR;
        5: o.opcode = OPC_OPIMM;
        6, 7: o.opcode = OPC_OP;
        default: o.opcode = 7'($urandom);
      endcase
      o.f3 = 3'($urandom); o.f1 = 1'($urandom);
      o.d1 = $urandom; o.d2 = ($urandom_range(0, 3) == 0) ? o.d1 : $urandom;
      o.imm = $urandom; o.off = $urandom & ~32'd1; o.pc = $urandom & ~32'd1;
      o.c = 1'($urandom); o.tag = 4'($urandom);
      e = model(o);
      applyStimulus(o);
      checkOutput("rand", e, o.tag);
    end

    // Rollback kills the in-flight op
    @(negedge clk);
    o = mk(OPC_OP, 3'd0, 1'b0, 1, 2, 0, 0, 0, 1'b0, 4'd9);
    driveOp(o);
    exe_valid = 1'b1;
    rollback = (LAT == 1);
    @(negedge clk);
    exe_valid = 1'b0;
    rollback = (LAT == 2);
    checkValue("rb_kill0", {31'b0, alu_valid}, 32'd0);
    @(negedge clk);
    rollback = 1'b0;
    checkValue("rb_kill1", {31'b0, alu_valid}, 32'd0);
    @(negedge clk);
    checkValue("rb_kill2", {31'b0, alu_valid}, 32'd0);
    o = mk(OPC_OP, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 0, 0, 0, 1'b0, 4'd6);
    applyStimulus(o);
    checkOutput("rb_after", ex(32'hFF00, 0, 0, 0), 4'd6);

    // Back-to-back issues with a two-cycle rdy stall
    @(negedge clk);
    prev_rdy = 1'b1;
    snap_valid = alu_valid; snap_rob = alu_rob_id; snap_data = alu_data;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (!prev_rdy) begin
          checkValue("stall_valid", {31'b0, alu_valid}, {31'b0, snap_valid});
          checkValue("stall_rob", {28'b0, alu_rob_id}, {28'b0, snap_rob});
          checkValue("stall_data", alu_data, snap_data);
        end else if (alu_valid) begin
          seen_tag.push_back(alu_rob_id);
          seen_data.push_back(alu_data);
        end
        snap_valid = alu_valid; snap_rob = alu_rob_id; snap_data = alu_data;
      end
      rdy = (c < 8) ? sched_rdy[c] : 1'b1;
      prev_rdy = rdy;
      if (c < 8 && sched_tag[c] != 0) begin
        driveOp(mk(OPC_OP, 3'd0, 1'b0, 32'(100 * sched_tag[c]), 32'(sched_tag[c]),
                   0, 0, 0, 1'b0, 4'(sched_tag[c])));
        exe_valid = 1'b1;
      end else begin
        exe_valid = 1'b0;
      end
    end
    rdy = 1'b1;
    exe_valid = 1'b0;
    checkValue("b2b_count", 32'(seen_tag.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < seen_tag.size()) begin
        checkValue($sformatf("b2b_tag%0d", k), {28'b0, seen_tag[k]}, 32'(k + 1));
        checkValue($sformatf("b2b_data%0d", k), seen_data[k], 32'(101 * (k + 1)));
      end else begin
        checkValue($sformatf("b2b_tag%0d", k), 32'hFFFFFFFF, 32'(k + 1));
      end
    end

    // Asynchronous reset mid-stream drops the broadcast without a clock edge
    o = mk(OPC_LUI, 3'd0, 1'b0, 0, 0, 32'hABCD0000, 0, 0, 1'b0, 4'd5);
    applyStimulus(o);
    checkValue("arst_pre_valid", {31'b0, alu_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkValue("arst_valid", {31'b0, alu_valid}, 32'd0);
    checkValue("arst_rob", {28'b0, alu_rob_id}, 32'd0);
    checkValue("arst_data", alu_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    o = mk(OPC_JAL, 3'd0, 1'b0, 0, 0, 0, 32'h10, 32'h80, 1'b0, 4'd3);
    applyStimulus(o);
    checkOutput("arst_after", ex(32'h84, 1, 1, 32'h90), 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
